clam_hash_lookup: RTL and testbench

Query engine for the hash/occurrence table written by the hash-building stage of the data-frequency extractor. It accepts one key at a time and recomputes the builder's tail hash. It then linearly probes the table through a synchronous read port and returns whether the key is present, its occurrence count and the number of slots examined. It sits beside the builder on the table's read side and serves host frequency queries after (or between) build passes.

---
 rtl/clam_hash_lookup_if.sv | 35 +++
 rtl/clam_hash_lookup.sv | 118 +++++++++++
 tb/tb_clam_hash_lookup.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clam_hash_lookup_if.sv
// Query/table-read/result bundle for the hash lookup engine.
// The engine takes the slave side; the host and the table read port take master.
interface clam_hash_lookup_if #(
   parameter int DATA_INDEX_WIDTH = 32,
   parameter int BIT_ON_TAILS     = 7
);
   localparam int ADDR_W = BIT_ON_TAILS + 1;

   logic                        query_valid;
   logic                        query_ready;
   logic [DATA_INDEX_WIDTH-1:0] query_key;

   logic                        rd_en;
   logic [ADDR_W-1:0]           rd_addr;
   logic [DATA_INDEX_WIDTH-1:0] rd_hash;
   logic [DATA_INDEX_WIDTH-1:0] rd_occurr;

   logic                        result_valid;
   logic                        result_ready;
   logic                        result_found;
   logic [DATA_INDEX_WIDTH-1:0] result_count;
   logic [BIT_ON_TAILS:0]       result_probes;

   modport master (
      output query_valid, query_key, rd_hash, rd_occurr, result_ready,
      input  query_ready, rd_en, rd_addr,
      input  result_valid, result_found, result_count, result_probes
   );

   modport slave (
      input  query_valid, query_key, rd_hash, rd_occurr, result_ready,
      output query_ready, rd_en, rd_addr,
      output result_valid, result_found, result_count, result_probes
   );
endinterface

// File: rtl/clam_hash_lookup.sv
// Hash table query engine: recomputes the builder's tail hash for one key,
// linearly probes the occurrence table through a 1-cycle synchronous read
// port and reports found / occurrence count / number of slots read.
module clam_hash_lookup #(
   parameter int DATA_INDEX_WIDTH = 32,
   parameter int BIT_ON_TAILS     = 7
) (
   input  logic              clk,
   input  logic              rst,
   clam_hash_lookup_if.slave bus,
   output logic              busy
);
   localparam int LEN    = 1 << BIT_ON_TAILS;
   localparam int ADDR_W = BIT_ON_TAILS + 1;
   localparam int PW     = BIT_ON_TAILS + 1;
   localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(LEN - 1);
   localparam logic [ADDR_W-1:0] LEN_A = ADDR_W'(LEN);
   localparam logic [PW-1:0]     PMAX  = PW'(LEN);

   typedef enum logic [2:0] {IDLE, HASH, WRAP, READ, CMP, RESP} state_t;

   state_t                      state_q, state_d;
   logic [DATA_INDEX_WIDTH-1:0] key_q;
   logic [ADDR_W-1:0]           idx_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [PW-1:0]               probes_q;
   logic                        found_q;
   logic [DATA_INDEX_WIDTH-1:0] count_q;

   // Slot outcome decoded once so FSM and datapath agree on priority:
   // an empty slot ends the search before any key compare.
   logic slot_empty, slot_hit, table_done;
   always_comb begin
      slot_empty = (bus.rd_occurr == '0);
      slot_hit   = !slot_empty && (bus.rd_hash == key_q);
      table_done = (probes_q == PMAX);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.query_valid) state_d = HASH;
         HASH: state_d = WRAP;
         WRAP: state_d = READ;
         READ: state_d = CMP;
         CMP:  begin
            if (slot_empty || slot_hit || table_done) state_d = RESP;
            else                                      state_d = READ;
         end
         RESP: if (bus.result_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: key latch, probe index, probe count and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q    <= '0;
         idx_q    <= '0;
         addr_q   <= '0;
         probes_q <= '0;
         found_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.query_valid) begin
                  key_q    <= bus.query_key;
                  probes_q <= '0;
               end
            end
            // Sum of two tail-sized values fits ADDR_W bits without overflow.
            HASH: idx_q <= {1'b0, key_q[BIT_ON_TAILS-1:0]} +
                           ADDR_W'(key_q[BIT_ON_TAILS-1:1]);
            // Single subtraction suffices: the sum never reaches 2*LEN.
            WRAP: if (idx_q > MASK) idx_q <= idx_q - LEN_A;
            READ: begin
               probes_q <= probes_q + PW'(1);
               addr_q   <= idx_q;
            end
            CMP: begin
               if (slot_empty) begin
                  found_q <= 1'b0;
                  count_q <= '0;
               end else if (slot_hit) begin
                  found_q <= 1'b1;
                  count_q <= bus.rd_occurr;
               end else if (table_done) begin
                  found_q <= 1'b0;
                  count_q <= '0;
               end else begin
                  idx_q <= (idx_q == MASK) ? '0 : idx_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state; rd_addr keeps the last probed slot between reads.
   always_comb begin
      bus.query_ready   = (state_q == IDLE) && !rst;
      bus.rd_en         = (state_q == READ);
      bus.rd_addr       = (state_q == READ) ? idx_q : addr_q;
      bus.result_valid  = (state_q == RESP);
      bus.result_found  = found_q;
      bus.result_count  = count_q;
      bus.result_probes = probes_q;
      busy              = (state_q != IDLE);
   end
endmodule

// File: tb/tb_clam_hash_lookup.sv
// Bench for clam_hash_lookup: table memory model behind a 1-cycle read port,
// reference probe model filling result and address scoreboards.
module tb_clam_hash_lookup;
   localparam int DW  = 32;
   localparam int BT  = 7;
   localparam int LEN = 1 << BT;

   typedef struct {
      logic          found;
      logic [DW-1:0] count;
      logic [BT:0]   probes;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   clam_hash_lookup_if #(.DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(BT)) bus ();

   clam_hash_lookup #(.DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(BT)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mhash [LEN];
   logic [DW-1:0] mocc  [LEN];
   exp_t          sb[$];
   logic [BT:0]   exp_addr[$];
   int            n_run = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            hs_cyc = 0;
   logic          rv_prev = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Synchronous table read port, data one cycle after rd_en.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.rd_en) begin
         bus.rd_hash   <= mhash[bus.rd_addr[BT-1:0]];
         bus.rd_occurr <= mocc[bus.rd_addr[BT-1:0]];
      end
   end

   // Monitor: read addresses, result latency and result contents.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.query_valid && bus.query_ready) hs_cyc = cyc;
         if (bus.rd_en) begin
            if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
            else                      chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
         end
         if (bus.result_valid && !rv_prev && sb.size() > 0)
            chk("latency", cyc - hs_cyc, 3 + 2 * int'(sb[0].probes));
         if (bus.result_valid && bus.result_ready) begin
            if (sb.size() == 0) chk("result_unexpected", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("found",  bus.result_found,  e.found);
               chk("count",  bus.result_count,  e.count);
               chk("probes", bus.result_probes, e.probes);
            end
         end
      end
      rv_prev = bus.result_valid && !rst;
   end

   function automatic int hash_of(input logic [DW-1:0] key);
      int t, h;
      t = int'(key[BT-1:0]);
      h = t + (t >> 1);
      if (h >= LEN) h -= LEN;
      return h;
   endfunction

   task automatic clear_tbl();
      for (int i = 0; i < LEN; i++) begin
         mhash[i] = '0;
         mocc[i]  = '0;
      end
   endtask

   // Builder-style insert: linear probe to the key or first empty slot.
   task automatic insert(input logic [DW-1:0] key, input logic [DW-1:0] occ);
      int a;
      a = hash_of(key);
      for (int i = 0; i < LEN; i++) begin
         if (mocc[a] == 0 || mhash[a] == key) begin
            mhash[a] = key;
            mocc[a]  = occ;
            return;
         end
         a = (a + 1) % LEN;
      end
   endtask

   task automatic query(input logic [DW-1:0] key);
      exp_t e;
      int a, n;
      e.found = 1'b0; e.count = '0; e.probes = '0;
      a = hash_of(key);
      for (int i = 0; i < LEN; i++) begin
         e.probes = e.probes + 1'b1;
         exp_addr.push_back((BT+1)'(a));
         if (mocc[a] == 0) break;
         if (mhash[a] == key) begin
            e.found = 1'b1;
            e.count = mocc[a];
            break;
         end
         a = (a + 1) % LEN;
      end
      n = 0;
      while (!bus.query_ready && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.query_ready) chk("ready_timeout", 0, 1);
      bus.query_valid = 1'b1;
      bus.query_key   = key;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.query_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk); n++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
      if (exp_addr.size() != 0) begin
         chk("reads_missing", exp_addr.size(), 0);
         exp_addr.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
      $fatal(1);
   end

   initial begin
      bus.query_valid  = 1'b0;
      bus.query_key    = '0;
      bus.result_ready = 1'b1;
      clear_tbl();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_qready", bus.query_ready,   0);
      chk("rst_rd_en",  bus.rd_en,         0);
      chk("rst_addr",   bus.rd_addr,       0);
      chk("rst_rvalid", bus.result_valid,  0);
      chk("rst_found",  bus.result_found,  0);
      chk("rst_count",  bus.result_count,  0);
      chk("rst_probes", bus.result_probes, 0);
      chk("rst_busy",   busy,              0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("qready_after_rst", bus.query_ready, 1);

      // Hit on first slot.
      @(posedge clk); #1;
      mhash[7] = 5; mocc[7] = 3;
      query(5);
      wait_done();

      // Collision chain 7 -> 8.
      clear_tbl();
      mhash[7] = 5; mocc[7] = 2; mhash[8] = 133; mocc[8] = 4;
      query(133);
      wait_done();

      // Miss on empty slot via hash wrap (190 -> 62), and key 0 on empty slot 0.
      clear_tbl();
      query(127);
      wait_done();
      query(0);
      wait_done();

      // Address wrap 127 -> 0, plus direct hit on 127.
      clear_tbl();
      mhash[127] = 85; mocc[127] = 1; mhash[0] = 213; mocc[0] = 6;
      query(213);
      query(85);
      wait_done();

      // Full table, no match: 128 probes.
      for (int i = 0; i < LEN; i++) begin
         mhash[i] = 1000 + i; mocc[i] = 1;
      end
      query(999);
      wait_done();

      // Backpressure: result held stable for 10 cycles.
      clear_tbl();
      mhash[7] = 5; mocc[7] = 3;
      bus.result_ready = 1'b0;
      query(5);
      begin
         int n = 0;
         while (!bus.result_valid && n < 100) begin @(negedge clk); n++; end
      end
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid",  bus.result_valid, 1);
         chk("bp_qready", bus.query_ready,  0);
         if (sb.size() > 0) begin
            chk("bp_found",  bus.result_found,  sb[0].found);
            chk("bp_count",  bus.result_count,  sb[0].count);
            chk("bp_probes", bus.result_probes, sb[0].probes);
         end
      end
      @(posedge clk); #1;
      bus.result_ready = 1'b1;
      wait_done();

      // Random keys inserted builder-style, then hits and misses.
      clear_tbl();
      begin
         logic [DW-1:0] keys[16];
         for (int i = 0; i < 16; i++) begin
            keys[i] = $urandom_range(1, 600);
            insert(keys[i], $urandom_range(1, 9));
         end
         for (int i = 0; i < 8; i++) begin
            query(keys[i]);
            query($urandom_range(601, 5000));
         end
      end
      wait_done();

      // Reset mid-probe aborts the lookup.
      for (int i = 0; i < LEN; i++) begin
         mhash[i] = 2000 + i; mocc[i] = 1;
      end
      query(999);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_rd_en",  bus.rd_en,        0);
      chk("abort_rvalid", bus.result_valid, 0);
      chk("abort_busy",   busy,             0);
      chk("abort_qready", bus.query_ready,  0);
      sb.delete();
      exp_addr.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_qready_rel", bus.query_ready, 1);
      @(posedge clk); #1;
      query(999);
      wait_done();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
